regfile_mp_sb: RTL and testbench

- Parametrised integer register file for the NPC core: NRD combinational read ports, NWR synchronous write ports, and same-cycle write-to-read bypass.
- Includes a per-register busy scoreboard (set at issue, cleared at writeback, bulk-cleared on flush) and a registered debug read port with req/ack handshake for difftest and monitor access.
- Sits between decode/issue and writeback, and replaces the single-write, non-resettable GPR array.

---
 rtl/rf_pkg.sv | 22 ++
 rtl/rf_scoreboard.sv | 61 ++++++
 rtl/regfile_mp_sb.sv | 123 ++++++++++++
 tb/tb_regfile_mp_sb.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// address-width helper, common data/address types and the debug FSM states.
package rf_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    // Address width needed to index n registers.
    function automatic int rf_aw(input int n);
        return $clog2(n);
    endfunction

    typedef logic [AW_DEF-1:0]   rf_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    typedef enum logic {
        DBG_IDLE,
        DBG_ACK
    } dbg_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, bulk-cleared
// on flush, plus the busy lookup seen by the read ports with writeback bypass.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NRD*rf_aw(NREG)-1:0]  rd_addr,
    output logic [NRD-1:0]              rd_busy,
    input  logic [NWR-1:0]              wr_en,
    input  logic [NWR*rf_aw(NREG)-1:0]  wr_addr,
    input  logic                        iss_en,
    input  logic [rf_aw(NREG)-1:0]      iss_addr,
    input  logic                        flush
);

    localparam int AW = rf_aw(NREG);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] wr_hit;
    logic [NREG-1:0] iss_hit;

    // Decode which registers are written back and which one is issued this cycle
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        wr_hit  = '0;
        iss_hit = '0;
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k]) wr_hit[wr_addr[k*AW +: AW]] = 1'b1;
        end
        if (iss_en) iss_hit[iss_addr] = 1'b1;
        if (ZERO_REG != 0) iss_hit[0] = 1'b0;
    end

    // Flush beats everything; a new producer beats a same-cycle writeback
    always_comb begin
        busy_next = flush ? '0 : ((busy & ~wr_hit) | iss_hit);
    end

    // Busy vector register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) busy <= '0;
        else        busy <= busy_next;
    end

    // Busy lookup for the read ports; a same-cycle writeback reads as not busy
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy[rd_addr[i*AW +: AW]] & ~wr_hit[rd_addr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Integer register file for the NPC core: NRD combinational read ports with
// write bypass, NWR write ports (highest index wins), busy scoreboard and a
// registered debug read port with a one-cycle ack.
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NRD*rf_aw(NREG)-1:0]  rd_addr,
    output logic [NRD*XLEN-1:0]         rd_data,
    output logic [NRD-1:0]              rd_busy,
    input  logic [NWR-1:0]              wr_en,
    input  logic [NWR*rf_aw(NREG)-1:0]  wr_addr,
    input  logic [NWR*XLEN-1:0]         wr_data,
    input  logic                        iss_en,
    input  logic [rf_aw(NREG)-1:0]      iss_addr,
    input  logic                        flush,
    input  logic                        dbg_req,
    input  logic [rf_aw(NREG)-1:0]      dbg_addr,
    output logic                        dbg_ack,
    output logic [XLEN-1:0]             dbg_rdata
);

    localparam int AW  = rf_aw(NREG);
    localparam int NLK = NRD + 1;   // read ports plus the debug port

    logic [NREG-1:0][XLEN-1:0] regs;
    logic [AW-1:0]             lk_addr [NLK];
    logic [XLEN-1:0]           lk_data [NLK];
    dbg_state_e                state;
    dbg_state_e                state_next;

    // Collect the read-port addresses and the debug address into one lookup list
    always_comb begin
        for (int i = 0; i < NRD; i++) lk_addr[i] = rd_addr[i*AW +: AW];
        lk_addr[NRD] = dbg_addr;
    end

    // Stored value with same-cycle write forwarding; later ports override earlier
    always_comb begin
        for (int i = 0; i < NLK; i++) begin
            lk_data[i] = regs[lk_addr[i]];
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] == lk_addr[i])) begin
                    lk_data[i] = wr_data[k*XLEN +: XLEN];
                end
            end
            if ((ZERO_REG != 0) && (lk_addr[i] == '0)) lk_data[i] = '0;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign rd_data[i*XLEN +: XLEN] = lk_data[i];
    end

    // Register array update
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the whole array is reset on purpose, so the file can be kept
            // in flops and every register reads a defined 0 after reset.
            regs <= '0;
        end else begin
            // NOTE: non-blocking updates in port order mean the last (highest
            // index) port targeting an address is the one that sticks.
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && !((ZERO_REG != 0) && (wr_addr[k*AW +: AW] == '0))) begin
                    regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Debug FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= DBG_IDLE;
        else        state <= state_next;
    end

    // Debug FSM next state: accept in IDLE, always return from ACK
    always_comb begin
        state_next = state;
        case (state)
            DBG_IDLE: if (dbg_req) state_next = DBG_ACK;
            DBG_ACK:  state_next = DBG_IDLE;
            default:  state_next = DBG_IDLE;
        endcase
    end

    // Debug FSM output: ack is high for the single cycle spent in ACK
    always_comb begin
        dbg_ack = (state == DBG_ACK);
    end

    // Debug data capture; the forwarded value is the register's post-edge value
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                          dbg_rdata <= '0;
        else if (state == DBG_IDLE && dbg_req) dbg_rdata <= lk_data[NRD];
    end

    rf_scoreboard #(
        .NREG     (NREG),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios plus a randomized
// run checked against a behavioural array model of the register file.
module tb_regfile_mp_sb;
    import rf_pkg::*;

    localparam int XLEN     = 64;
    localparam int NREG     = 32;
    localparam int NRD      = 2;
    localparam int NWR      = 2;
    localparam int ZERO_REG = 1;
    localparam int AW       = 5;

    logic                clock;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic                dbg_req;
    logic [AW-1:0]       dbg_addr;
    logic                dbg_ack;
    logic [XLEN-1:0]     dbg_rdata;

    int tests_run = 0;
    int failures  = 0;

    // Behavioural model
    xlen_t m_regs [NREG];
    bit    m_busy [NREG];
    bit    m_ack_due;
    xlen_t m_dbg_data;

    regfile_mp_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(ZERO_REG)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .dbg_req  (dbg_req),
        .dbg_addr (dbg_addr),
        .dbg_ack  (dbg_ack),
        .dbg_rdata(dbg_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic set_idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
        dbg_req = 1'b0; dbg_addr = '0; rd_addr = '0;
    endtask

    task automatic set_wr(input int k, input int a, input xlen_t d);
        wr_en[k] = 1'b1;
        wr_addr[k*AW +: AW] = AW'(a);
        wr_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int i, input int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    function automatic xlen_t get_rd(input int i);
        return rd_data[i*XLEN +: XLEN];
    endfunction

    // Expected combinational read: stored value, overridden by the last enabled writer
    function automatic xlen_t exp_data(input int a);
        xlen_t v;
        if (a == 0) return '0;
        v = m_regs[a];
        for (int k = 0; k < NWR; k++)
            if (wr_en[k] && wr_addr[k*AW +: AW] == AW'(a)) v = wr_data[k*XLEN +: XLEN];
        return v;
    endfunction

    function automatic bit exp_busy(input int a);
        bit b;
        b = m_busy[a];
        for (int k = 0; k < NWR; k++)
            if (wr_en[k] && wr_addr[k*AW +: AW] == AW'(a)) b = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        m_ack_due  = 1'b0;
        m_dbg_data = '0;
    endtask

    // Apply the rules of one rising edge to the model, using the inputs held across it
    task automatic model_edge();
        bit hit [NREG];
        for (int r = 0; r < NREG; r++) hit[r] = 1'b0;
        for (int k = 0; k < NWR; k++) if (wr_en[k]) hit[int'(wr_addr[k*AW +: AW])] = 1'b1;
        for (int k = 0; k < NWR; k++)
            if (wr_en[k] && wr_addr[k*AW +: AW] != '0)
                m_regs[int'(wr_addr[k*AW +: AW])] = wr_data[k*XLEN +: XLEN];
        for (int r = 0; r < NREG; r++) begin
            if (flush) m_busy[r] = 1'b0;
            else m_busy[r] = (m_busy[r] && !hit[r]) || (iss_en && iss_addr == AW'(r) && r != 0);
        end
        if (m_ack_due) m_ack_due = 1'b0;
        else if (dbg_req) begin
            m_ack_due  = 1'b1;
            m_dbg_data = m_regs[int'(dbg_addr)];
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        if (!reset) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < NRD; i++) begin
            tests_run++;
            if (get_rd(i) !== '0 || rd_busy[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_read[%0d]: got data=%h busy=%b expected 0/0", i, get_rd(i), rd_busy[i]);
            end
        end
        tests_run++;
        if (dbg_ack !== 1'b0 || dbg_rdata !== '0) begin
            failures++;
            $display("FAIL reset_dbg: got ack=%b rdata=%h expected 0/0", dbg_ack, dbg_rdata);
        end
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic test_bypass();
        set_idle();
        set_wr(0, 5, 64'hDEAD_BEEF_0000_0001);
        set_rd(0, 5);
        #1;
        tests_run++;
        if (get_rd(0) !== 64'hDEAD_BEEF_0000_0001) begin
            failures++;
            $display("FAIL bypass_same_cycle: got %h expected %h", get_rd(0), 64'hDEAD_BEEF_0000_0001);
        end
        cycle();
        set_idle();
        set_rd(0, 5);
        #1;
        tests_run++;
        if (get_rd(0) !== 64'hDEAD_BEEF_0000_0001) begin
            failures++;
            $display("FAIL bypass_stored: got %h expected %h", get_rd(0), 64'hDEAD_BEEF_0000_0001);
        end
    endtask

    task automatic test_zero_reg();
        set_idle();
        set_wr(0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        iss_en = 1'b1; iss_addr = '0;
        set_rd(0, 0); set_rd(1, 0);
        #1;
        tests_run++;
        if (get_rd(0) !== '0) begin
            failures++;
            $display("FAIL zero_same_cycle: got %h expected 0", get_rd(0));
        end
        cycle();
        set_idle();
        for (int n = 0; n < 3; n++) begin
            #1;
            for (int i = 0; i < NRD; i++) begin
                tests_run++;
                if (get_rd(i) !== '0 || rd_busy[i] !== 1'b0) begin
                    failures++;
                    $display("FAIL zero_later[%0d]: got data=%h busy=%b expected 0/0", i, get_rd(i), rd_busy[i]);
                end
            end
            cycle();
        end
    endtask

    task automatic test_scoreboard();
        set_idle(); iss_en = 1'b1; iss_addr = AW'(13); set_rd(0, 13); #1;
        tests_run++;
        if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL sb_issue_not_same_cycle: got %b expected 0", rd_busy[0]); end
        cycle();
        set_idle(); iss_en = 1'b1; iss_addr = AW'(7); cycle();
        set_idle(); set_rd(0, 7); #1;
        tests_run++;
        if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL sb_issue: got %b expected 1", rd_busy[0]); end
        set_idle(); iss_en = 1'b1; iss_addr = AW'(7); set_wr(0, 7, 64'h77); set_rd(0, 7); cycle();
        set_idle(); set_rd(0, 7); #1;
        tests_run++;
        if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL sb_issue_wins: got %b expected 1", rd_busy[0]); end
        set_wr(0, 7, 64'h78); #1;
        tests_run++;
        if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL sb_wb_bypass: got %b expected 0", rd_busy[0]); end
        cycle();
        set_idle(); set_rd(0, 7); #1;
        tests_run++;
        if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL sb_wb_cleared: got %b expected 0", rd_busy[0]); end
        set_idle(); iss_en = 1'b1; iss_addr = AW'(9); flush = 1'b1; cycle();
        set_idle(); set_rd(1, 9); #1;
        tests_run++;
        if (rd_busy[1] !== 1'b0) begin failures++; $display("FAIL sb_flush_beats_issue: got %b expected 0", rd_busy[1]); end
        set_idle(); iss_en = 1'b1; iss_addr = AW'(11); cycle();
        set_idle(); flush = 1'b1; cycle();
        set_idle(); set_rd(1, 11); set_rd(0, 13); #1;
        tests_run++;
        if (rd_busy !== 2'b00) begin failures++; $display("FAIL sb_flush_clears: got %b expected 00", rd_busy); end
    endtask

    task automatic test_write_priority();
        set_idle();
        set_wr(0, 3, 64'h11);
        set_wr(1, 3, 64'h22);
        set_rd(0, 3);
        #1;
        tests_run++;
        if (get_rd(0) !== 64'h22) begin failures++; $display("FAIL prio_bypass: got %h expected 22", get_rd(0)); end
        cycle();
        set_idle(); set_rd(1, 3); #1;
        tests_run++;
        if (get_rd(1) !== 64'h22) begin failures++; $display("FAIL prio_stored: got %h expected 22", get_rd(1)); end
    endtask

    task automatic test_debug();
        set_idle(); dbg_req = 1'b1; dbg_addr = AW'(3); cycle();
        tests_run++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== 64'h22) begin
            failures++; $display("FAIL dbg_first_ack: got ack=%b rdata=%h expected 1/22", dbg_ack, dbg_rdata);
        end
        cycle();
        tests_run++;
        if (dbg_ack !== 1'b0) begin failures++; $display("FAIL dbg_ack_pulse: got %b expected 0", dbg_ack); end
        dbg_req = 1'b0; cycle();
        tests_run++;
        if (dbg_ack !== 1'b0 || dbg_rdata !== 64'h22) begin
            failures++; $display("FAIL dbg_second_dropped: got ack=%b rdata=%h expected 0/22", dbg_ack, dbg_rdata);
        end
        set_idle(); dbg_req = 1'b1; dbg_addr = AW'(6); set_wr(1, 6, 64'h0606_A5A5_0606_A5A5); cycle();
        set_idle();
        tests_run++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== 64'h0606_A5A5_0606_A5A5) begin
            failures++; $display("FAIL dbg_post_edge: got ack=%b rdata=%h expected 1/0606a5a50606a5a5", dbg_ack, dbg_rdata);
        end
        cycle();
        dbg_req = 1'b1; dbg_addr = AW'(3); cycle();
        dbg_req = 1'b0; reset = 1'b0; model_reset(); #1;
        tests_run++;
        if (dbg_ack !== 1'b0 || dbg_rdata !== '0) begin
            failures++; $display("FAIL dbg_abort_reset: got ack=%b rdata=%h expected 0/0", dbg_ack, dbg_rdata);
        end
        cycle();
        reset = 1'b1;
        for (int n = 0; n < 2; n++) begin
            cycle();
            tests_run++;
            if (dbg_ack !== 1'b0) begin failures++; $display("FAIL dbg_abort_no_ack: got %b expected 0", dbg_ack); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_idle();
            for (int k = 0; k < NWR; k++) begin
                if ($urandom_range(0, 1) == 1)
                    set_wr(k, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NREG-1),
                           {$urandom(), $urandom()});
            end
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = AW'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 15) == 0);
            dbg_req  = ($urandom_range(0, 2) == 0);
            dbg_addr = AW'($urandom_range(0, 7));
            for (int i = 0; i < NRD; i++) set_rd(i, $urandom_range(0, 7));
            #1;
            for (int i = 0; i < NRD; i++) begin
                tests_run++;
                if (get_rd(i) !== exp_data(int'(rd_addr[i*AW +: AW]))) begin
                    failures++;
                    $display("FAIL rand_rd_data[%0d] iter %0d: got %h expected %h", i, n, get_rd(i), exp_data(int'(rd_addr[i*AW +: AW])));
                end
                tests_run++;
                if (rd_busy[i] !== exp_busy(int'(rd_addr[i*AW +: AW]))) begin
                    failures++;
                    $display("FAIL rand_rd_busy[%0d] iter %0d: got %b expected %b", i, n, rd_busy[i], exp_busy(int'(rd_addr[i*AW +: AW])));
                end
            end
            cycle();
            tests_run++;
            if (dbg_ack !== m_ack_due || dbg_rdata !== m_dbg_data) begin
                failures++;
                $display("FAIL rand_dbg iter %0d: got ack=%b rdata=%h expected %b/%h", n, dbg_ack, dbg_rdata, m_ack_due, m_dbg_data);
            end
        end
    endtask

    task automatic test_reset_midstream();
        set_idle();
        set_wr(0, 5, 64'h1234); set_wr(1, 12, 64'h5678);
        iss_en = 1'b1; iss_addr = AW'(20);
        cycle();
        #2;
        reset = 1'b0;
        model_reset();
        set_idle();
        cycle();
        cycle();
        reset = 1'b1;
        for (int a = 0; a < NREG; a++) begin
            set_rd(0, a); set_rd(1, NREG - 1 - a);
            #1;
            for (int i = 0; i < NRD; i++) begin
                tests_run++;
                if (get_rd(i) !== '0 || rd_busy[i] !== 1'b0) begin
                    failures++;
                    $display("FAIL post_reset_read addr %0d port %0d: got data=%h busy=%b expected 0/0", a, i, get_rd(i), rd_busy[i]);
                end
            end
        end
        tests_run++;
        if (dbg_ack !== 1'b0) begin failures++; $display("FAIL post_reset_ack: got %b expected 0", dbg_ack); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_write_priority();
        test_debug();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
